// File: rtl/alu_regfile_seq.sv
// Eight-entry register file sequenced against an external registered ALU: IDLE -> ISSUE -> WB, one instruction per 3 cycles.
// Latency: result visible 3 edges after accept; backpressure: o_ready is high only in IDLE, illegal opcodes retire next cycle via o_err.
module alu_regfile_seq (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_valid,
  output logic       o_ready,
  input  logic [2:0] i_op,
  input  logic [2:0] i_rd,
  input  logic [2:0] i_rs,
  input  logic       i_use_imm,
  input  logic [7:0] i_imm,
  input  logic       i_use_carry,
  output logic [7:0] o_alu_a,
  output logic [7:0] o_alu_b,
  output logic [2:0] o_alu_op,
  output logic       o_alu_cin,
  input  logic [7:0] i_alu_result,
  input  logic       i_alu_c,
  input  logic       i_alu_v,
  input  logic       i_alu_n,
  input  logic       i_alu_z,
  output logic       o_done,
  output logic       o_err,
  output logic [3:0] o_flags,
  input  logic [2:0] i_dbg_addr,
  output logic [7:0] o_dbg_data
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WB} state_t;

  state_t     state_q, state_d;
  logic [7:0] regs_q [8];
  logic [7:0] regs_d [8];
  logic [3:0] flags_q, flags_d;

  logic [2:0] op_q, op_d;
  logic [2:0] rd_q, rd_d;
  logic [2:0] rs_q, rs_d;
  logic       use_imm_q, use_imm_d;
  logic [7:0] imm_q, imm_d;
  logic       use_carry_q, use_carry_d;

  logic [7:0] alu_a_q, alu_a_d;
  logic [7:0] alu_b_q, alu_b_d;
  logic [2:0] alu_op_q, alu_op_d;
  logic       alu_cin_q, alu_cin_d;
  logic       done_q, done_d;
  logic       err_q, err_d;

  always_comb begin
    state_d     = state_q;
    regs_d      = regs_q;
    flags_d     = flags_q;
    op_d        = op_q;
    rd_d        = rd_q;
    rs_d        = rs_q;
    use_imm_d   = use_imm_q;
    imm_d       = imm_q;
    use_carry_d = use_carry_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    alu_cin_d   = alu_cin_q;
    done_d      = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          op_d        = i_op;
          rd_d        = i_rd;
          rs_d        = i_rs;
          use_imm_d   = i_use_imm;
          imm_d       = i_imm;
          use_carry_d = i_use_carry;
          // Opcodes above XOR retire immediately without touching the ALU or state.
          if (i_op > 3'd4) begin
            err_d = 1'b1;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        alu_a_d   = regs_q[rd_q];
        alu_b_d   = use_imm_q ? imm_q : regs_q[rs_q];
        alu_op_d  = op_q;
        alu_cin_d = use_carry_q & flags_q[3];
        done_d    = 1'b1;
        state_d   = S_WB;
      end
      S_WB: begin
        regs_d[rd_q] = i_alu_result;
        flags_d      = {i_alu_c, i_alu_v, i_alu_n, i_alu_z};
        state_d      = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      for (int i = 0; i < 8; i++) begin
        regs_q[i] <= 8'h00;
      end
      flags_q     <= 4'h0;
      op_q        <= 3'd0;
      rd_q        <= 3'd0;
      rs_q        <= 3'd0;
      use_imm_q   <= 1'b0;
      imm_q       <= 8'h00;
      use_carry_q <= 1'b0;
      alu_a_q     <= 8'h00;
      alu_b_q     <= 8'h00;
      alu_op_q    <= 3'd0;
      alu_cin_q   <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      regs_q      <= regs_d;
      flags_q     <= flags_d;
      op_q        <= op_d;
      rd_q        <= rd_d;
      rs_q        <= rs_d;
      use_imm_q   <= use_imm_d;
      imm_q       <= imm_d;
      use_carry_q <= use_carry_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      alu_cin_q   <= alu_cin_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // Operands are live during ISSUE and held from the hold registers otherwise.
  assign o_alu_a    = alu_a_d;
  assign o_alu_b    = alu_b_d;
  assign o_alu_op   = alu_op_d;
  assign o_alu_cin  = alu_cin_d;
  assign o_ready    = i_rst_n && (state_q == S_IDLE);
  assign o_done     = done_q;
  assign o_err      = err_q;
  assign o_flags    = flags_q;
  assign o_dbg_data = regs_q[i_dbg_addr];

endmodule

// File: tb/tb_alu_regfile_seq.sv
// Bench for alu_regfile_seq: registered ALU model, directed vector table, randomized run against a register-file model.
module tb_alu_regfile_seq;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_valid = 1'b0;
  logic       o_ready;
  logic [2:0] i_op = 3'd0;
  logic [2:0] i_rd = 3'd0;
  logic [2:0] i_rs = 3'd0;
  logic       i_use_imm = 1'b0;
  logic [7:0] i_imm = 8'h00;
  logic       i_use_carry = 1'b0;
  logic [7:0] o_alu_a;
  logic [7:0] o_alu_b;
  logic [2:0] o_alu_op;
  logic       o_alu_cin;
  logic [7:0] i_alu_result = 8'h00;
  logic       i_alu_c = 1'b0;
  logic       i_alu_v = 1'b0;
  logic       i_alu_n = 1'b0;
  logic       i_alu_z = 1'b0;
  logic       o_done;
  logic       o_err;
  logic [3:0] o_flags;
  logic [2:0] i_dbg_addr = 3'd0;
  logic [7:0] o_dbg_data;

  alu_regfile_seq dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_op(i_op), .i_rd(i_rd), .i_rs(i_rs), .i_use_imm(i_use_imm), .i_imm(i_imm),
    .i_use_carry(i_use_carry), .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_alu_op(o_alu_op),
    .o_alu_cin(o_alu_cin), .i_alu_result(i_alu_result), .i_alu_c(i_alu_c), .i_alu_v(i_alu_v),
    .i_alu_n(i_alu_n), .i_alu_z(i_alu_z), .o_done(o_done), .o_err(o_err), .o_flags(o_flags),
    .i_dbg_addr(i_dbg_addr), .o_dbg_data(o_dbg_data)
  );

  always #5 i_clk = ~i_clk;

  // Arithmetic from first principles: returns {result, C, V, N, Z}.
  function automatic logic [11:0] alu_f(input logic [2:0] op, input logic [7:0] a,
                                        input logic [7:0] b, input logic cin);
    int u, s;
    logic [7:0] res;
    logic c, v;
    c = 1'b0; v = 1'b0; res = 8'h00;
    case (op)
      3'd0: begin
        u = int'(a) + int'(b) + int'(cin);
        s = int'($signed(a)) + int'($signed(b)) + int'(cin);
        res = u[7:0]; c = (u > 255); v = (s > 127) || (s < -128);
      end
      3'd1: begin
        u = int'(a) - int'(b) - int'(cin);
        s = int'($signed(a)) - int'($signed(b)) - int'(cin);
        res = u[7:0]; c = (u < 0); v = (s > 127) || (s < -128);
      end
      3'd2: res = a & b;
      3'd3: res = a | b;
      3'd4: res = a ^ b;
      default: res = 8'h00;
    endcase
    return {res, c, v, res[7], (res == 8'h00)};
  endfunction

  // External ALU: one-cycle registered.
  always @(posedge i_clk) begin
    {i_alu_result, i_alu_c, i_alu_v, i_alu_n, i_alu_z} <= alu_f(o_alu_op, o_alu_a, o_alu_b, o_alu_cin);
  end

  int n_tests = 0;
  int n_fail = 0;
  logic [7:0] m_r [8];
  logic [3:0] m_flags;
  logic [2:0] last_op;
  logic [7:0] last_a;

  typedef struct {
    logic [2:0] op;
    logic [2:0] rd;
    logic [2:0] rs;
    logic       ui;
    logic [7:0] imm;
    logic       uc;
    logic [7:0] er;
    logic [3:0] ef;
  } vec_t;
  vec_t vecs [10];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_r[i] = 8'h00;
    m_flags = 4'h0;
    last_op = 3'd0;
    last_a = 8'h00;
  endtask

  task automatic read_reg(input logic [2:0] addr, output logic [7:0] val);
    i_dbg_addr = addr;
    #1;
    val = o_dbg_data;
  endtask

  task automatic run(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs,
                     input logic ui, input logic [7:0] imm, input logic uc);
    logic [7:0] a, b, d;
    logic cin;
    logic [11:0] exp;
    a = m_r[rd];
    b = ui ? imm : m_r[rs];
    cin = uc ? m_flags[3] : 1'b0;
    exp = alu_f(op, a, b, cin);
    chk("ready_before_accept", o_ready, 1);
    i_op = op; i_rd = rd; i_rs = rs; i_use_imm = ui; i_imm = imm; i_use_carry = uc;
    i_valid = 1'b1;
    step();
    i_valid = 1'b0;
    i_op = 3'($urandom); i_rd = 3'($urandom); i_rs = 3'($urandom); i_imm = 8'($urandom);
    chk("issue_ready", o_ready, 0);
    chk("issue_done", o_done, 0);
    chk("issue_alu_a", o_alu_a, a);
    chk("issue_alu_b", o_alu_b, b);
    chk("issue_alu_op", o_alu_op, op);
    chk("issue_alu_cin", o_alu_cin, cin);
    step();
    chk("wb_done", o_done, 1);
    chk("wb_ready", o_ready, 0);
    read_reg(rd, d);
    chk("wb_dbg_old", d, a);
    step();
    m_r[rd] = exp[11:4];
    m_flags = exp[3:0];
    last_op = op;
    last_a = a;
    chk("post_done", o_done, 0);
    chk("post_ready", o_ready, 1);
    chk("post_flags", o_flags, m_flags);
    chk("post_alu_a_hold", o_alu_a, last_a);
    read_reg(rd, d);
    chk("post_dbg_new", d, m_r[rd]);
  endtask

  task automatic run_illegal(input logic [2:0] op, input logic [2:0] rd);
    logic [7:0] d;
    i_op = op; i_rd = rd; i_rs = 3'($urandom); i_use_imm = 1'b1; i_imm = 8'($urandom);
    i_use_carry = 1'b0;
    i_valid = 1'b1;
    step();
    i_valid = 1'b0;
    chk("ill_err", o_err, 1);
    chk("ill_done", o_done, 0);
    chk("ill_ready", o_ready, 1);
    chk("ill_alu_op_held", o_alu_op, last_op);
    step();
    chk("ill_err_clear", o_err, 0);
    chk("ill_done2", o_done, 0);
    chk("ill_ready2", o_ready, 1);
    chk("ill_flags", o_flags, m_flags);
    read_reg(rd, d);
    chk("ill_reg", d, m_r[rd]);
  endtask

  initial begin
    logic [7:0] d;
    vecs[0] = '{3'd0, 3'd1, 3'd0, 1'b1, 8'h05, 1'b0, 8'h05, 4'b0000};
    vecs[1] = '{3'd0, 3'd1, 3'd0, 1'b1, 8'h7A, 1'b0, 8'h7F, 4'b0000};
    vecs[2] = '{3'd0, 3'd1, 3'd0, 1'b1, 8'h01, 1'b0, 8'h80, 4'b0110};
    vecs[3] = '{3'd1, 3'd2, 3'd0, 1'b1, 8'h01, 1'b0, 8'hFF, 4'b1010};
    vecs[4] = '{3'd0, 3'd3, 3'd0, 1'b1, 8'hFF, 1'b0, 8'hFF, 4'b0010};
    vecs[5] = '{3'd0, 3'd3, 3'd0, 1'b1, 8'h01, 1'b0, 8'h00, 4'b1001};
    vecs[6] = '{3'd0, 3'd4, 3'd0, 1'b1, 8'h00, 1'b1, 8'h01, 4'b0000};
    vecs[7] = '{3'd3, 3'd6, 3'd1, 1'b0, 8'h00, 1'b0, 8'h80, 4'b0010};
    vecs[8] = '{3'd4, 3'd6, 3'd6, 1'b0, 8'h00, 1'b0, 8'h00, 4'b0001};
    vecs[9] = '{3'd1, 3'd1, 3'd1, 1'b0, 8'h00, 1'b1, 8'h00, 4'b0001};

    model_reset();
    i_rst_n = 1'b0;
    step();
    step();
    chk("rst_ready_held", o_ready, 0);
    chk("rst_done", o_done, 0);
    chk("rst_err", o_err, 0);
    i_rst_n = 1'b1;
    #1;
    chk("idle_ready", o_ready, 1);
    chk("idle_flags", o_flags, 0);
    chk("idle_alu_a", o_alu_a, 0);
    chk("idle_alu_b", o_alu_b, 0);
    chk("idle_alu_op", o_alu_op, 0);
    chk("idle_alu_cin", o_alu_cin, 0);
    for (int i = 0; i < 8; i++) begin
      read_reg(3'(i), d);
      chk("idle_dbg", d, 0);
    end
    step();

    for (int i = 0; i < 10; i++) begin
      if (i == 7) run_illegal(3'd6, 3'd1);
      run(vecs[i].op, vecs[i].rd, vecs[i].rs, vecs[i].ui, vecs[i].imm, vecs[i].uc);
      read_reg(vecs[i].rd, d);
      chk("vec_result", d, vecs[i].er);
      chk("vec_flags", o_flags, vecs[i].ef);
    end

    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        run_illegal(3'($urandom_range(5, 7)), 3'($urandom));
      end else begin
        run(3'($urandom_range(0, 4)), 3'($urandom), 3'($urandom), 1'($urandom),
            8'($urandom), 1'($urandom));
      end
      repeat ($urandom_range(0, 2)) step();
    end

    // Seed r5 with a nonzero value so a reset that skips the clear is visible.
    run(3'd3, 3'd5, 3'd0, 1'b1, 8'hA5, 1'b0);
    model_reset();
    i_op = 3'd0; i_rd = 3'd5; i_use_imm = 1'b1; i_imm = 8'h33; i_use_carry = 1'b0;
    i_valid = 1'b1;
    step();
    i_valid = 1'b0;
    step();
    chk("abort_in_wb", o_done, 1);
    i_rst_n = 1'b0;
    step();
    chk("abort_ready_held", o_ready, 0);
    chk("abort_done", o_done, 0);
    step();
    i_rst_n = 1'b1;
    #1;
    chk("abort_ready_release", o_ready, 1);
    chk("abort_flags", o_flags, 0);
    chk("abort_alu_a", o_alu_a, 0);
    for (int i = 0; i < 8; i++) begin
      read_reg(3'(i), d);
      chk("abort_dbg", d, 0);
    end
    step();
    chk("abort_done_after", o_done, 0);

    i_op = 3'd0; i_rd = 3'd2; i_use_imm = 1'b1; i_imm = 8'h44;
    i_valid = 1'b1;
    step();
    i_valid = 1'b0;
    i_rst_n = 1'b0;
    step();
    i_rst_n = 1'b1;
    #1;
    chk("abort_issue_ready", o_ready, 1);
    step();
    chk("abort_issue_done", o_done, 0);
    read_reg(3'd2, d);
    chk("abort_issue_reg", d, 0);

    run(3'd0, 3'd2, 3'd0, 1'b1, 8'h10, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
